// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each transaction takes one cycle each in IDLE (grant), ACCESS (memory op) and RESP (ack).
module dmem_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [31:0]      addr0,
  input  logic [31:0]      addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             err,
  output logic             stall0,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  // state  | meaning
  // IDLE   | wait for a request, pick a winner and latch it
  // ACCESS | drive the memory with the latched transaction, capture rdata/err
  // RESP   | pulse the ack of the latched port
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t           state, state_nxt;
  logic             grant, win;
  logic             lat_we, lat_port, last_grant;
  logic [31:0]      lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic             in_range;

  assign in_range = (lat_addr < DEPTH_U);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    win       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          win       = (req0 && req1) ? ~last_grant : req1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latched transaction doubles as the memory address/data bus, so it holds outside ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we     <= 1'b0;
      lat_port   <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      last_grant <= 1'b1;
    end else if (grant) begin
      lat_we     <= win ? we1 : we0;
      lat_port   <= win;
      lat_addr   <= win ? addr1 : addr0;
      lat_wdata  <= win ? wdata1 : wdata0;
      last_grant <= win;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (state == ACCESS) begin
      rdata <= in_range ? mem_rdata : '0;
      err   <= ~in_range;
    end
  end

  assign mem_we    = (state == ACCESS) && lat_we && in_range;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign ack0      = (state == RESP) && !lat_port;
  assign ack1      = (state == RESP) && lat_port;
  assign stall0    = req0 && !ack0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural memory sits on the mem_* bus and
// expected responses are queued as requests are issued, then checked on every ack.
module tb_dmem_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 128;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1, we0, we1;
  logic [31:0]      addr0, addr1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             ack0, ack1, err, stall0, mem_we;
  logic [WIDTH-1:0] rdata, mem_wdata, mem_rdata;
  logic [31:0]      mem_addr;

  dmem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .stall0(stall0),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] exp_mem [DEPTH];

  always @(posedge clk) if (mem_we && mem_addr < 32'(DEPTH)) mem[mem_addr[6:0]] <= mem_wdata;
  assign mem_rdata = (mem_addr < 32'(DEPTH)) ? mem[mem_addr[6:0]] : '0;

  typedef struct {
    logic             port;
    logic [WIDTH-1:0] rdata;
    logic             err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void expect_txn(input logic port, input logic we,
                                     input logic [31:0] addr, input logic [WIDTH-1:0] wdata);
    exp_t e;
    e.port = port;
    if (addr < 32'(DEPTH)) begin
      e.err   = 1'b0;
      e.rdata = exp_mem[addr[6:0]];
      if (we) exp_mem[addr[6:0]] = wdata;
    end else begin
      e.err   = 1'b1;
      e.rdata = '0;
    end
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (ack0 || ack1) begin
      chk("ack_onehot", 64'(ack0 & ack1), 64'd0);
      if (sb.size() == 0) chk("ack_unexpected", 64'(ack0 | ack1), 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("ack_port", 64'(ack1), 64'(mon_e.port));
        chk("rdata", 64'(rdata), 64'(mon_e.rdata));
        chk("err", 64'(err), 64'(mon_e.err));
      end
    end
  end

  task automatic do_txn(input logic port, input logic we,
                        input logic [31:0] addr, input logic [WIDTH-1:0] wdata);
    int   cyc;
    logic got;
    @(negedge clk);
    expect_txn(port, we, addr, wdata);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    #1;
    if (!port) chk("stall0_grant", 64'(stall0), 64'd1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 6) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("mem_we_access", 64'(mem_we), 64'(we && addr < 32'(DEPTH)));
        chk("mem_addr", 64'(mem_addr), 64'(addr));
        if (we) chk("mem_wdata", 64'(mem_wdata), 64'(wdata));
        if (!port) chk("stall0_access", 64'(stall0), 64'd1);
      end
      if (ack0 || ack1) got = 1'b1;
    end
    chk("ack_latency", 64'(cyc), 64'd2);
    chk("mem_we_resp", 64'(mem_we), 64'd0);
    if (!port) chk("stall0_ack", 64'(stall0), 64'd0);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Both ports read continuously; port 0 is expected to win first, then strict alternation.
  task automatic contend(input int n, input logic [31:0] a0, input logic [31:0] a1,
                         input logic do_reset);
    int cnt;
    @(negedge clk);
    if (do_reset) reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = a0;
    req1 = 1'b1; we1 = 1'b0; addr1 = a1;
    for (int i = 0; i < n; i++) expect_txn(i[0], 1'b0, i[0] ? a1 : a0, '0);
    if (do_reset) begin
      @(negedge clk);
      reset = 1'b0;
    end
    cnt = 0;
    for (int c = 0; c < 8 * n && cnt < n; c++) begin
      @(negedge clk);
      if (ack0 || ack1) cnt++;
    end
    chk("contend_acks", 64'(cnt), 64'(n));
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ack0", 64'(ack0), 64'd0);
    chk("rst_ack1", 64'(ack1), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b0;

    do_txn(1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
    do_txn(1'b1, 1'b0, 32'd5, '0);
    do_txn(1'b0, 1'b1, 32'd128, 32'h0000_0055);
    do_txn(1'b1, 1'b1, 32'd127, 32'h0000_A5A5);
    do_txn(1'b0, 1'b0, 32'd127, '0);
    do_txn(1'b1, 1'b0, 32'h8000_0005, '0);
    do_txn(1'b0, 1'b0, 32'hFFFF_FFFF, '0);

    contend(4, 32'd127, 32'd5, 1'b1);

    // Abort a write in ACCESS; the word must survive and arbitration must restart at port 0.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5; wdata0 = 32'h1234_5678;
    @(negedge clk);
    chk("abort_mem_we_pre", 64'(mem_we), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_mem_we", 64'(mem_we), 64'd0);
    chk("abort_rdata", 64'(rdata), 64'd0);
    chk("abort_mem_addr", 64'(mem_addr), 64'd0);
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    contend(2, 32'd5, 32'd127, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
